// File: rtl/tpm_startup_sequencer.sv
// TPM startup/shutdown sequencer: gates commands until a valid TPM2_Startup,
// picks the startup type from SU and the NV orderly word, and runs self-test.
module tpm_startup_sequencer #(
  parameter int         CC_W              = 32,
  parameter int         RC_W              = 32,
  parameter int         MAX_STARTUP_FAILS = 3,
  parameter int         SELFTEST_TIMEOUT  = 256,
  parameter logic [7:0] LOCALITY_MASK     = 8'h01
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tpm_init,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CC_W-1:0] cmd_cc,
  input  logic [32:0]     cmd_param,
  input  logic [7:0]      locality,
  input  logic [15:0]     orderly_in,
  output logic            selftest_start,
  input  logic            selftest_done,
  input  logic            selftest_pass,
  output logic            rsp_valid,
  output logic [RC_W-1:0] rsp_rc,
  output logic            exec_valid,
  output logic [2:0]      op_state,
  output logic [2:0]      startup_type,
  output logic [15:0]     shutdown_save,
  output logic            nv_write,
  output logic [3:0]      fail_count
);

  localparam logic [2:0] ST_POWER_OFF = 3'b000;
  localparam logic [2:0] ST_INIT      = 3'b001;
  localparam logic [2:0] ST_STARTUP   = 3'b010;
  localparam logic [2:0] ST_OPER      = 3'b011;
  localparam logic [2:0] ST_SELFTEST  = 3'b100;
  localparam logic [2:0] ST_FAILURE   = 3'b101;

  localparam logic [2:0] SU_NONE    = 3'b000;
  localparam logic [2:0] SU_RESET   = 3'b001;
  localparam logic [2:0] SU_RESTART = 3'b010;
  localparam logic [2:0] SU_RESUME  = 3'b011;
  localparam logic [2:0] SU_TYPE    = 3'b100;

  localparam logic [CC_W-1:0] CC_STARTUP  = CC_W'(32'h144);
  localparam logic [CC_W-1:0] CC_SHUTDOWN = CC_W'(32'h145);

  localparam logic [RC_W-1:0] RC_SUCCESS    = RC_W'(32'h000);
  localparam logic [RC_W-1:0] RC_VALUE      = RC_W'(32'h084);
  localparam logic [RC_W-1:0] RC_INITIALIZE = RC_W'(32'h100);
  localparam logic [RC_W-1:0] RC_FAILURE    = RC_W'(32'h101);
  localparam logic [RC_W-1:0] RC_LOCALITY   = RC_W'(32'h907);

  localparam int              CNT_W    = $clog2(SELFTEST_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SELFTEST_TIMEOUT - 1);
  localparam logic [3:0]      MAX_FAILS = 4'(MAX_STARTUP_FAILS);

  typedef struct packed {
    logic        su;
    logic [15:0] orderly;
  } startReq_t;

  startReq_t        req;
  logic [CNT_W-1:0] stCnt;
  logic             accept;
  logic             isStartup;
  logic             isShutdown;
  logic             locOk;
  logic             orderlySaved;
  logic [3:0]       failNext;
  logic             unusedParamBits;

  assign unusedParamBits = ^cmd_param[32:1];

  assign cmd_ready = ((op_state == ST_INIT) || (op_state == ST_OPER) || (op_state == ST_FAILURE))
                     && !rsp_valid && !exec_valid;
  assign accept       = cmd_valid && cmd_ready;
  assign isStartup    = (cmd_cc == CC_STARTUP);
  assign isShutdown   = (cmd_cc == CC_SHUTDOWN);
  assign locOk        = (locality < 8'd8) && LOCALITY_MASK[locality[2:0]];
  assign orderlySaved = (req.orderly == 16'h0001);
  assign failNext     = (fail_count >= MAX_FAILS) ? fail_count : fail_count + 4'd1;

  // tpm_init outranks a command presented in the same cycle; that command is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_state       <= ST_POWER_OFF;
      startup_type   <= SU_NONE;
      shutdown_save  <= 16'hFFFF;
      fail_count     <= '0;
      rsp_valid      <= 1'b0;
      rsp_rc         <= '0;
      exec_valid     <= 1'b0;
      nv_write       <= 1'b0;
      selftest_start <= 1'b0;
      stCnt          <= '0;
      req            <= '0;
    end else begin
      rsp_valid      <= 1'b0;
      exec_valid     <= 1'b0;
      nv_write       <= 1'b0;
      selftest_start <= 1'b0;
      if (accept) begin
        req.su      <= cmd_param[0];
        req.orderly <= orderly_in;
      end
      case (op_state)
        ST_POWER_OFF: begin
          if (tpm_init) begin
            op_state     <= ST_INIT;
            startup_type <= SU_NONE;
          end
        end
        ST_INIT: begin
          if (tpm_init) begin
            startup_type <= SU_NONE;
          end else if (accept) begin
            if (isStartup && locOk) begin
              op_state <= ST_STARTUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rc    <= isStartup ? RC_LOCALITY : RC_INITIALIZE;
            end
          end
        end
        ST_STARTUP: begin
          if (tpm_init) begin
            op_state     <= ST_INIT;
            startup_type <= SU_NONE;
          end else if (req.su && !orderlySaved) begin
            // STATE requested without a saved state: a counted failure
            startup_type <= SU_TYPE;
            rsp_valid    <= 1'b1;
            rsp_rc       <= RC_VALUE;
            fail_count   <= failNext;
            op_state     <= (failNext >= MAX_FAILS) ? ST_FAILURE : ST_INIT;
          end else begin
            startup_type   <= req.su ? SU_RESUME : (orderlySaved ? SU_RESTART : SU_RESET);
            op_state       <= ST_SELFTEST;
            selftest_start <= 1'b1;
            stCnt          <= '0;
            shutdown_save  <= 16'hFFFF;
            nv_write       <= 1'b1;
          end
        end
        ST_SELFTEST: begin
          if (tpm_init) begin
            op_state     <= ST_INIT;
            startup_type <= SU_NONE;
          end else if (selftest_done) begin
            rsp_valid <= 1'b1;
            if (selftest_pass) begin
              op_state   <= ST_OPER;
              rsp_rc     <= RC_SUCCESS;
              fail_count <= '0;
            end else begin
              op_state <= ST_FAILURE;
              rsp_rc   <= RC_FAILURE;
            end
          end else if (stCnt == CNT_LAST) begin
            op_state  <= ST_FAILURE;
            rsp_valid <= 1'b1;
            rsp_rc    <= RC_FAILURE;
          end else begin
            stCnt <= stCnt + CNT_W'(1);
          end
        end
        ST_OPER: begin
          if (tpm_init) begin
            op_state     <= ST_INIT;
            startup_type <= SU_NONE;
          end else if (accept) begin
            if (isStartup) begin
              rsp_valid <= 1'b1;
              rsp_rc    <= RC_INITIALIZE;
            end else if (isShutdown) begin
              rsp_valid <= 1'b1;
              if (locOk) begin
                rsp_rc        <= RC_SUCCESS;
                shutdown_save <= {15'b0, cmd_param[0]};
                nv_write      <= 1'b1;
              end else begin
                rsp_rc <= RC_LOCALITY;
              end
            end else begin
              exec_valid <= 1'b1;
            end
          end
        end
        ST_FAILURE: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rc    <= RC_FAILURE;
          end
        end
        default: op_state <= ST_POWER_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_startup_sequencer.sv
// Directed-plus-random bench for tpm_startup_sequencer with a behavioural
// model of startup decisions, fail counting and OPERATIONAL command handling.
module tb_tpm_startup_sequencer;
  localparam int         CC_W = 32;
  localparam int         RC_W = 32;
  localparam int         MAXF = 3;
  localparam int         TMO  = 256;
  localparam logic [7:0] LOCM = 8'h01;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            tpm_init = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [CC_W-1:0] cmd_cc = '0;
  logic [32:0]     cmd_param = '0;
  logic [7:0]      locality = '0;
  logic [15:0]     orderly_in = '0;
  logic            selftest_start;
  logic            selftest_done = 1'b0;
  logic            selftest_pass = 1'b0;
  logic            rsp_valid;
  logic [RC_W-1:0] rsp_rc;
  logic            exec_valid;
  logic [2:0]      op_state;
  logic [2:0]      startup_type;
  logic [15:0]     shutdown_save;
  logic            nv_write;
  logic [3:0]      fail_count;

  int          nTests = 0;
  int          nFail  = 0;
  int          mFail  = 0;
  logic [15:0] mSave  = 16'hFFFF;

  always #5 clock = ~clock;

  tpm_startup_sequencer #(
    .CC_W(CC_W), .RC_W(RC_W), .MAX_STARTUP_FAILS(MAXF),
    .SELFTEST_TIMEOUT(TMO), .LOCALITY_MASK(LOCM)
  ) dut (
    .clock(clock), .reset(reset), .tpm_init(tpm_init),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cc(cmd_cc),
    .cmd_param(cmd_param), .locality(locality), .orderly_in(orderly_in),
    .selftest_start(selftest_start), .selftest_done(selftest_done),
    .selftest_pass(selftest_pass), .rsp_valid(rsp_valid), .rsp_rc(rsp_rc),
    .exec_valid(exec_valid), .op_state(op_state), .startup_type(startup_type),
    .shutdown_save(shutdown_save), .nv_write(nv_write), .fail_count(fail_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic bit locAllowed(input logic [7:0] loc);
    logic [7:0] m;
    m = LOCM;
    return (loc < 8'd8) && m[loc[2:0]];
  endfunction

  // Startup type table: saved state exists only for orderly 0x0001
  function automatic logic [2:0] expType(input bit su, input logic [15:0] ord);
    bit saved;
    saved = (ord == 16'h0001);
    if (su) return saved ? 3'd3 : 3'd4;
    return saved ? 3'd2 : 3'd1;
  endfunction

  task automatic checkReset(input string tag);
    chk({tag, "_op_state"}, op_state, 0);
    chk({tag, "_startup_type"}, startup_type, 0);
    chk({tag, "_shutdown_save"}, shutdown_save, 32'hFFFF);
    chk({tag, "_fail_count"}, fail_count, 0);
    chk({tag, "_strobes"}, {cmd_ready, rsp_valid, exec_valid, nv_write, selftest_start}, 0);
    chk({tag, "_rsp_rc"}, rsp_rc, 0);
  endtask

  task automatic doReset;
    reset = 1'b1;
    cmd_valid = 1'b0; tpm_init = 1'b0; selftest_done = 1'b0;
    repeat (2) tick;
    checkReset("reset");
    reset = 1'b0;
    mFail = 0;
    mSave = 16'hFFFF;
    tick;
  endtask

  task automatic doInit;
    tpm_init = 1'b1;
    tick;
    tpm_init = 1'b0;
    chk("init_op_state", op_state, 1);
    chk("init_startup_type", startup_type, 0);
    chk("init_cmd_ready", cmd_ready, 1);
  endtask

  task automatic sendCmd(input logic [31:0] cc, input bit su, input logic [7:0] loc,
                         input logic [15:0] ord);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_cc     = cc;
    cmd_param  = {32'($urandom), su};
    locality   = loc;
    orderly_in = ord;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic immCmd(input string tag, input logic [31:0] cc, input bit su,
                        input logic [7:0] loc, input bit expRsp, input logic [31:0] expRc,
                        input bit expExec, input bit expNv);
    sendCmd(cc, su, loc, 16'($urandom));
    chk({tag, "_rsp_valid"}, rsp_valid, expRsp);
    if (expRsp) chk({tag, "_rsp_rc"}, rsp_rc, expRc);
    chk({tag, "_exec_valid"}, exec_valid, expExec);
    chk({tag, "_nv_write"}, nv_write, expNv);
    if (expNv) chk({tag, "_shutdown_save"}, shutdown_save, mSave);
    tick;
    chk({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  task automatic opCmd(input string tag, input logic [31:0] cc, input bit su, input logic [7:0] loc);
    if (cc == 32'h144) immCmd(tag, cc, su, loc, 1, 32'h100, 0, 0);
    else if (cc == 32'h145 && locAllowed(loc)) begin
      mSave = {15'b0, su};
      immCmd(tag, cc, su, loc, 1, 32'h000, 0, 1);
    end else if (cc == 32'h145) immCmd(tag, cc, su, loc, 1, 32'h907, 0, 0);
    else immCmd(tag, cc, su, loc, 0, 0, 1, 0);
    chk({tag, "_op_state"}, op_state, 3);
  endtask

  // delay >= TMO means selftest_done is never raised
  task automatic startupSeq(input string tag, input bit su, input logic [15:0] ord,
                            input int delay, input bit pass);
    logic [2:0] t;
    bit early;
    int cnt;
    t = expType(su, ord);
    sendCmd(32'h144, su, 8'd0, ord);
    chk({tag, "_op_startup"}, op_state, 2);
    chk({tag, "_no_early_rsp"}, rsp_valid, 0);
    tick;
    chk({tag, "_startup_type"}, startup_type, t);
    if (t == 3'd4) begin
      mFail = (mFail < MAXF) ? mFail + 1 : MAXF;
      chk({tag, "_type_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_type_rc"}, rsp_rc, 32'h084);
      chk({tag, "_fail_count"}, fail_count, mFail);
      chk({tag, "_type_op_state"}, op_state, (mFail >= MAXF) ? 5 : 1);
      tick;
      return;
    end
    mSave = 16'hFFFF;
    chk({tag, "_op_selftest"}, op_state, 4);
    chk({tag, "_selftest_start"}, selftest_start, 1);
    chk({tag, "_nv_write"}, nv_write, 1);
    chk({tag, "_save_consumed"}, shutdown_save, mSave);
    if (delay >= TMO) begin
      cnt = 0;
      while (!rsp_valid && cnt < TMO + 4) begin
        tick;
        cnt++;
      end
      chk({tag, "_timeout_cycles"}, cnt, TMO);
      chk({tag, "_timeout_rc"}, rsp_rc, 32'h101);
      chk({tag, "_timeout_op_state"}, op_state, 5);
      tick;
      return;
    end
    early = 1'b0;
    for (int i = 0; i < delay; i++) begin
      tick;
      early |= rsp_valid;
    end
    selftest_done = 1'b1;
    selftest_pass = pass;
    tick;
    selftest_done = 1'b0;
    chk({tag, "_no_rsp_before_done"}, early, 0);
    chk({tag, "_st_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_st_rc"}, rsp_rc, pass ? 32'h000 : 32'h101);
    chk({tag, "_st_op_state"}, op_state, pass ? 3 : 5);
    if (pass) mFail = 0;
    chk({tag, "_st_fail_count"}, fail_count, mFail);
    tick;
  endtask

  initial begin
    logic [31:0] cc;
    logic [15:0] ord;
    bit su;
    bit saw;
    int r;

    // reset and INIT rejects
    tick;
    doReset;
    chk("power_off_ready", cmd_ready, 0);
    doInit;
    immCmd("init_other_cc", 32'h0000_0150 + $urandom_range(0, 15), 0, 0, 1, 32'h100, 0, 0);
    immCmd("init_shutdown", 32'h145, 1, 0, 1, 32'h100, 0, 0);
    immCmd("init_startup_loc3", 32'h144, 0, 8'd3, 1, 32'h907, 0, 0);
    immCmd("init_startup_locrand", 32'h144, 0, 8'($urandom_range(1, 255)), 1, 32'h907, 0, 0);
    chk("init_stays", op_state, 1);

    // directed startup types
    startupSeq("su_clear_ord0", 0, 16'h0000, 5, 1);
    chk("shutdown_save_after_reset", shutdown_save, 32'hFFFF);
    doInit;
    startupSeq("su_clear_ord1", 0, 16'h0001, 5, 1);
    doInit;
    startupSeq("su_state_ord1", 1, 16'h0001, 5, 1);

    // OPERATIONAL directed commands
    opCmd("op_shutdown_state_loc0", 32'h145, 1, 8'd0);
    opCmd("op_shutdown_loc3", 32'h145, 1, 8'd3);
    opCmd("op_startup", 32'h144, 0, 8'd0);
    opCmd("op_exec_17e", 32'h17E, 0, 8'd0);
    chk("op_save_kept", shutdown_save, mSave);

    // OPERATIONAL random commands
    for (int k = 0; k < 16; k++) begin
      r  = $urandom_range(0, 3);
      su = 1'($urandom);
      cc = (r == 0) ? 32'h144 : (r == 3) ? (32'h2000_0000 | $urandom_range(0, 255)) : 32'h145;
      opCmd("op_rand", cc, su, 8'($urandom_range(0, 3)));
    end

    // random successful startups
    for (int k = 0; k < 4; k++) begin
      doInit;
      su  = 1'($urandom);
      ord = su ? 16'h0001 : 16'($urandom);
      startupSeq("rand_startup", su, ord, $urandom_range(0, 30), 1);
    end

    // tpm_init aborts self-test silently
    doInit;
    sendCmd(32'h144, 0, 8'd0, 16'h0000);
    tick;
    tick;
    tpm_init = 1'b1;
    tick;
    tpm_init = 1'b0;
    chk("abort_op_state", op_state, 1);
    chk("abort_startup_type", startup_type, 0);
    chk("abort_no_rsp", rsp_valid, 0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      saw |= rsp_valid | selftest_start;
    end
    chk("abort_quiet", saw, 0);

    // one TYPE failure, then success clears the count, then failing self-test
    startupSeq("type_once", 1, 16'h0000, 0, 1);
    startupSeq("clear_after_type", 0, 16'h1234, 3, 1);
    doInit;
    startupSeq("selftest_fail", 1, 16'h0001, 7, 0);
    immCmd("failure_cmd", 32'h17E, 0, 0, 1, 32'h101, 0, 0);
    tpm_init = 1'b1;
    tick;
    tpm_init = 1'b0;
    chk("failure_ignores_init", op_state, 5);

    // lockout after MAXF consecutive TYPE results
    doReset;
    doInit;
    for (int k = 1; k <= MAXF; k++) begin
      ord = 16'($urandom);
      if (ord == 16'h0001) ord = 16'h0000;
      startupSeq("lockout", 1, ord, 0, 1);
      if (k < MAXF) doInit;
    end
    chk("lockout_fail_count", fail_count, MAXF);
    immCmd("lockout_cmd", 32'h144, 0, 0, 1, 32'h101, 0, 0);

    // asynchronous reset mid-sequence
    doReset;
    doInit;
    sendCmd(32'h144, 0, 8'd0, 16'h0000);
    chk("midrst_startup", op_state, 2);
    reset = 1'b1;
    #1;
    checkReset("midrst");
    tick;
    reset = 1'b0;
    mFail = 0;
    tick;
    chk("midrst_power_off", op_state, 0);
    chk("midrst_no_rsp", rsp_valid, 0);

    // self-test timeout
    doInit;
    startupSeq("timeout", 0, 16'h0000, TMO, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
